wb_irq_ctrl: RTL

- Wishbone-slave interrupt controller that consumes the `irq` outputs of the peripheral blocks (misc/LED/button block, UART, timers) and presents one interrupt line to the CPU.
- Provides per-source enable, per-source edge/level mode, latched pending bits with write-1-to-clear, a global enable, and a priority-encoded claim register so the ISR can find the active source with one read.

---
 rtl/wb_irq_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: per-source enable, edge/level mode, W1C pending, global enable and claim register.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchroniser on irq_i for sources from other clock domains.
module wb_irq_ctrl #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int N_IRQ = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_reset_i,
    input  logic [AW-1:0]    wb_adr_i,
    input  logic [DW-1:0]    wb_dat_i,
    output logic [DW-1:0]    wb_dat_o,
    input  logic             wb_we_i,
    input  logic [DW/8-1:0]  wb_sel_i,
    output logic             wb_ack_o,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic [N_IRQ-1:0] irq_i,
    output logic             cpu_irq_o
);

    logic [N_IRQ-1:0] r_enable;
    logic [N_IRQ-1:0] r_mode;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_prev;
    logic             r_gie;
    logic             r_ack;
    logic             r_cpuIrq;
    logic [DW-1:0]    r_dat;

    logic [N_IRQ-1:0] w_s;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_active;
    logic [N_IRQ-1:0] w_pendNext;
    logic [4:0]       w_claimIdx;
    logic [DW-1:0]    w_rdata;
    logic             w_stbValid;
    logic             w_wr;
    logic             w_unused;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] r_sync1;
    logic [N_IRQ-1:0] r_sync2;

    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = irq_i;
`endif

    assign w_stbValid = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr       = w_stbValid & wb_we_i & wb_sel_i[0];
    assign w_clr      = (w_wr && wb_adr_i[3:0] == 4'h0) ? wb_dat_i[N_IRQ-1:0] : '0;
    assign w_rise     = w_s & ~r_prev;
    assign w_active   = r_pending & r_enable;
    // Level bits track the input; edge bits latch rises, and a rise beats a same-cycle clear.
    assign w_pendNext = (~r_mode & w_s) | (r_mode & ((r_pending & ~w_clr) | w_rise));
    assign w_unused   = &{1'b0, wb_adr_i[AW-1:4], wb_dat_i[DW-1:N_IRQ], wb_sel_i[DW/8-1:1]};

    always_comb begin
        w_claimIdx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_claimIdx = 5'(i);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (wb_adr_i[3:0])
            4'h0: w_rdata[N_IRQ-1:0] = r_pending;
            4'h1: w_rdata[N_IRQ-1:0] = r_enable;
            4'h2: w_rdata[N_IRQ-1:0] = r_mode;
            4'h3: w_rdata[0]         = r_gie;
            4'h4: w_rdata[N_IRQ-1:0] = w_s;
            4'h5: begin
                w_rdata[DW-1] = |w_active;
                w_rdata[4:0]  = w_claimIdx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            r_enable  <= '0;
            r_mode    <= '0;
            r_pending <= '0;
            r_prev    <= '0;
            r_gie     <= 1'b0;
            r_ack     <= 1'b0;
            r_cpuIrq  <= 1'b0;
            r_dat     <= '0;
        end else begin
            r_ack     <= w_stbValid;
            r_prev    <= w_s;
            r_pending <= w_pendNext;
            r_cpuIrq  <= r_gie & |w_active;
            if (w_stbValid) begin
                r_dat <= wb_we_i ? '0 : w_rdata;
            end
            if (w_wr) begin
                case (wb_adr_i[3:0])
                    4'h1:    r_enable <= wb_dat_i[N_IRQ-1:0];
                    4'h2:    r_mode   <= wb_dat_i[N_IRQ-1:0];
                    4'h3:    r_gie    <= wb_dat_i[0];
                    default: ;
                endcase
            end
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_dat_o  = r_dat;
    assign cpu_irq_o = r_cpuIrq;

endmodule
